hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard detection and forwarding control for a 5-stage in-order pipeline.
//   A shadow copy of the EX, MEM and WB stage descriptors is kept here so that
//   load-use stalls, branch flushes, memory freezes and EX operand forwarding
//   can all be decided from the ID-stage instruction plus this shadow.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   id_valid                     ID stage holds a real instruction
//   id_rs, id_rt                 ID source registers
//   id_uses_rs, id_uses_rt       ID instruction reads rs / rt
//   id_dst, id_reg_write         ID destination register and write enable
//   id_mem_read                  ID instruction is a load
//   branch_taken                 branch/jump in EX resolved taken
//   mem_busy                     data memory not ready, whole pipeline freezes
//   stall_pc, stall_ifid         hold PC / IF-ID register
//   flush_ifid                   clear IF-ID register to NOP
//   bubble_idex                  load NOP into ID-EX register
//   fwd_a, fwd_b                 EX operand selects: 00 regfile, 01 WB, 10 MEM
//   stall_cnt                    saturating count of cycles with stall_pc=1
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] dst;
    logic       reg_write;
    logic       mem_read;
  } stage_t;

  // One pipeline action per cycle, chosen by priority.
  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_FREEZE = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_LU     = 2'd3
  } act_t;

  stage_t ex_reg, mem_reg, wb_reg;
  stage_t ex_next, mem_next, wb_next;
  stage_t id_entry;
  act_t   act;
  logic   lu_hit;
  logic [CNT_W-1:0] stall_cnt_reg;

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = id_valid;
    id_entry.rs        = id_rs;
    id_entry.rt        = id_rt;
    id_entry.uses_rs   = id_uses_rs;
    id_entry.uses_rt   = id_uses_rt;
    id_entry.dst       = id_dst;
    id_entry.reg_write = id_reg_write;
    id_entry.mem_read  = id_mem_read;
  end

  // A load in EX whose (non-zero) destination is read by the ID instruction.
  assign lu_hit = ex_reg.valid & ex_reg.mem_read & (ex_reg.dst != 5'd0) & id_valid &
                  ((id_uses_rs & (id_rs == ex_reg.dst)) |
                   (id_uses_rt & (id_rt == ex_reg.dst)));

  always_comb begin
    act = ACT_RUN;
    if (mem_busy)          act = ACT_FREEZE;
    else if (branch_taken) act = ACT_FLUSH;
    else if (lu_hit)       act = ACT_LU;
  end

  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    case (act)
      ACT_FREEZE: begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
      end
      ACT_FLUSH: begin
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
      ACT_LU: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
      default: ;
    endcase
  end

  // Shadow advance: a freeze holds everything; flush and load-use push a
  // bubble into EX so the load moves on to MEM and the stall cannot repeat.
  always_comb begin
    ex_next  = ex_reg;
    mem_next = mem_reg;
    wb_next  = wb_reg;
    if (act != ACT_FREEZE) begin
      wb_next  = mem_reg;
      mem_next = ex_reg;
      ex_next  = (act == ACT_RUN) ? id_entry : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg        <= '0;
      mem_reg       <= '0;
      wb_reg        <= '0;
      stall_cnt_reg <= '0;
    end else begin
      ex_reg  <= ex_next;
      mem_reg <= mem_next;
      wb_reg  <= wb_next;
      if (stall_pc && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;

  // Forwarding: operand 0 is rs (fwd_a), operand 1 is rt (fwd_b).
  logic [1:0][4:0] op_reg;
  logic [1:0]      op_use;
  logic [1:0][1:0] op_sel;

  assign op_reg[0] = ex_reg.rs;
  assign op_reg[1] = ex_reg.rt;
  assign op_use[0] = ex_reg.uses_rs;
  assign op_use[1] = ex_reg.uses_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic needs;
    logic mem_hit;
    logic wb_hit;
    // r0 is hard-wired zero, so it never forwards; an empty EX never forwards.
    assign needs   = ex_reg.valid & op_use[gi] & (op_reg[gi] != 5'd0);
    assign mem_hit = needs & mem_reg.valid & mem_reg.reg_write & (mem_reg.dst == op_reg[gi]);
    assign wb_hit  = needs & wb_reg.valid & wb_reg.reg_write & (wb_reg.dst == op_reg[gi]);
    // The younger (MEM) result wins over the older (WB) one.
    assign op_sel[gi] = mem_hit ? 2'b10 : (wb_hit ? 2'b01 : 2'b00);
  end

  assign fwd_a = op_sel[0];
  assign fwd_b = op_sel[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl: a directed vector table, a few
//   multi-cycle hand sequences and a randomized run against a reference model.
//   A second instance with CNT_W=4 exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
  logic       branch_taken, mem_busy;

  logic        stall_pc, stall_ifid, flush_ifid, bubble_idex;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  logic        s_stall_pc, s_stall_ifid, s_flush_ifid, s_bubble_idex;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_stall_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .bubble_idex(bubble_idex), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid), .flush_ifid(s_flush_ifid),
    .bubble_idex(s_bubble_idex), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt)
  );

  // ------------------------------------------------------------------ model
  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] dst;
    logic       rw, mr;
  } ins_t;

  ins_t m_pipe [3];   // [0]=EX, [1]=MEM, [2]=WB
  int   m_cnt16;
  int   m_cnt4;
  logic [3:0] ctl_of [4];  // {stall_pc, stall_ifid, flush_ifid, bubble_idex}

  function automatic ins_t empty_ins();
    ins_t e;
    e.v = 0; e.rs = 0; e.rt = 0; e.urs = 0; e.urt = 0; e.dst = 0; e.rw = 0; e.mr = 0;
    return e;
  endfunction

  function automatic ins_t cur_id();
    ins_t e;
    e.v = id_valid; e.rs = id_rs; e.rt = id_rt; e.urs = id_uses_rs; e.urt = id_uses_rt;
    e.dst = id_dst; e.rw = id_reg_write; e.mr = id_mem_read;
    return e;
  endfunction

  function automatic bit reads(ins_t i, logic [4:0] r);
    return (i.urs && i.rs == r) || (i.urt && i.rt == r);
  endfunction

  // 0 run, 1 freeze, 2 flush, 3 load-use
  function automatic int m_action();
    ins_t ex = m_pipe[0];
    if (mem_busy) return 1;
    if (branch_taken) return 2;
    if (ex.v && ex.mr && ex.dst != 0 && id_valid && reads(cur_id(), ex.dst)) return 3;
    return 0;
  endfunction

  // Search older stages youngest-first for the producer of register r.
  function automatic int m_fwd(logic [4:0] r, logic used);
    if (!m_pipe[0].v || !used || r == 0) return 0;
    for (int k = 1; k <= 2; k++)
      if (m_pipe[k].v && m_pipe[k].rw && m_pipe[k].dst == r) return 3 - k;
    return 0;
  endfunction

  task automatic model_clock();
    int a;
    if (rst) begin
      for (int k = 0; k < 3; k++) m_pipe[k] = empty_ins();
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else begin
      a = m_action();
      if (ctl_of[a][3]) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      if (a != 1) begin
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = (a == 0) ? cur_id() : empty_ins();
      end
    end
  endtask

  // ------------------------------------------------------------------ checks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dst = dst; id_reg_write = rw; id_mem_read = mr;
  endtask

  // Called #1 after a rising edge with inputs already applied.
  task automatic run_cycle(input string tag, input bit have_exp, input logic [3:0] e_ctl,
                           input logic [1:0] e_fa, input logic [1:0] e_fb);
    logic [3:0] ctl;
    logic [1:0] fa, fb;
    @(negedge clk);
    if (have_exp) begin
      ctl = e_ctl; fa = e_fa; fb = e_fb;
    end else begin
      ctl = ctl_of[m_action()];
      fa  = 2'(m_fwd(m_pipe[0].rs, m_pipe[0].urs));
      fb  = 2'(m_fwd(m_pipe[0].rt, m_pipe[0].urt));
    end
    chk({tag, ".stall_pc"},    32'(stall_pc),    32'(ctl[3]));
    chk({tag, ".stall_ifid"},  32'(stall_ifid),  32'(ctl[2]));
    chk({tag, ".flush_ifid"},  32'(flush_ifid),  32'(ctl[1]));
    chk({tag, ".bubble_idex"}, 32'(bubble_idex), 32'(ctl[0]));
    chk({tag, ".fwd_a"},       32'(fwd_a),       32'(fa));
    chk({tag, ".fwd_b"},       32'(fwd_b),       32'(fb));
    chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'(m_cnt16));
    chk({tag, ".stall_cnt4"},  32'(s_stall_cnt), 32'(m_cnt4));
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; branch_taken = 0; mem_busy = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("reset", 1, 4'b0000, 2'b00, 2'b00);
    rst = 0;
  endtask

  // ------------------------------------------------------------------ table
  typedef struct {
    logic v; logic [4:0] rs, rt; logic urs, urt; logic [4:0] dst; logic rw, mr;
    logic br, busy; logic [3:0] ctl; logic [1:0] fa, fb;
  } vec_t;

  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic [4:0] dst, logic rw, logic mr, logic br, logic busy,
                              logic [3:0] ctl, logic [1:0] fa, logic [1:0] fb);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.urs = urs; t.urt = urt; t.dst = dst; t.rw = rw;
    t.mr = mr; t.br = br; t.busy = busy; t.ctl = ctl; t.fa = fa; t.fb = fb;
    return t;
  endfunction

  vec_t tbl [$];
  int   cnt_before;

  initial begin
    ctl_of[0] = 4'b0000; ctl_of[1] = 4'b1100; ctl_of[2] = 4'b0011; ctl_of[3] = 4'b1101;
    for (int k = 0; k < 3; k++) m_pipe[k] = empty_ins();
    m_cnt16 = 0; m_cnt4 = 0;

    // ALU chain, load-use, branch over load-use, r0 writes, MEM-over-WB.
    tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 4'b0000, 0, 0)); // add r3
    tbl.push_back(mk(1, 3, 6, 1, 1, 4, 1, 0, 0, 0, 4'b0000, 0, 0)); // sub r4,r3,r6
    tbl.push_back(mk(1, 3, 8, 1, 1, 7, 1, 0, 0, 0, 4'b0000, 2, 0)); // or r7,r3,r8
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 9, 0, 1, 0, 5, 1, 1, 0, 0, 4'b0000, 0, 0)); // lw r5
    tbl.push_back(mk(1,11, 5, 1, 1,10, 1, 0, 0, 0, 4'b1101, 0, 0)); // add uses r5
    tbl.push_back(mk(1,11, 5, 1, 1,10, 1, 0, 0, 0, 4'b0000, 0, 0)); // replayed
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 6, 1, 1, 0, 0, 4'b0000, 0, 0)); // lw r6
    tbl.push_back(mk(1, 6, 1, 1, 1, 2, 1, 0, 1, 0, 4'b0011, 0, 0)); // LU + branch
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0)); // write r0
    tbl.push_back(mk(1, 2, 0, 1, 0, 0, 1, 0, 0, 0, 4'b0000, 0, 0)); // write r0
    tbl.push_back(mk(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 4'b0000, 0, 0)); // reads r0,r0
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0)); // lw r0
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 0)); // uses r0
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 4'b0000, 0, 0)); // add r8
    tbl.push_back(mk(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 4'b0000, 0, 0)); // add r8
    tbl.push_back(mk(1, 8, 8, 1, 1,12, 1, 0, 0, 0, 4'b0000, 0, 0)); // sub r12,r8,r8
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));

    rst = 1; branch_taken = 0; mem_busy = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      set_id(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].dst, tbl[i].rw, tbl[i].mr);
      branch_taken = tbl[i].br; mem_busy = tbl[i].busy;
      run_cycle($sformatf("vec%0d", i), 1, tbl[i].ctl, tbl[i].fa, tbl[i].fb);
    end

    // mem_busy for 3 cycles while a load-use is pending.
    do_reset();
    cnt_before = m_cnt16;
    set_id(1, 1, 2, 1, 1, 9, 1, 0);  run_cycle("busy.add", 1, 4'b0000, 0, 0);
    set_id(1, 9, 0, 1, 0, 5, 1, 1);  run_cycle("busy.lw", 1, 4'b0000, 0, 0);
    set_id(1, 11, 5, 1, 1, 10, 1, 0);
    mem_busy = 1;
    for (int i = 0; i < 3; i++) run_cycle($sformatf("busy.frz%0d", i), 1, 4'b1100, 2, 0);
    mem_busy = 0;
    run_cycle("busy.lu", 1, 4'b1101, 2, 0);
    run_cycle("busy.go", 1, 4'b0000, 0, 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    run_cycle("busy.fwd", 1, 4'b0000, 0, 1);
    chk("busy.cnt_delta", 32'(stall_cnt), 32'(cnt_before + 4));

    // Reset in the middle of a load-use stall.
    set_id(1, 9, 0, 1, 0, 5, 1, 1);  run_cycle("rstlu.lw", 0, 0, 0, 0);
    set_id(1, 11, 5, 1, 1, 10, 1, 0);
    rst = 1;                         run_cycle("rstlu.in", 0, 0, 0, 0);
    rst = 0;                         run_cycle("rstlu.post", 1, 4'b0000, 0, 0);

    // Counter saturation on the 4-bit instance, then reset clears it.
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    mem_busy = 1;
    for (int i = 0; i < 20; i++) run_cycle($sformatf("sat%0d", i), 0, 0, 0, 0);
    mem_busy = 0;
    @(negedge clk);
    chk("sat.cnt4", 32'(s_stall_cnt), 32'd15);
    @(posedge clk); model_clock(); #1;
    do_reset();
    chk("sat.cnt4_cleared", 32'(s_stall_cnt), 32'd0);
    chk("sat.cnt16_cleared", 32'(stall_cnt), 32'd0);
    chk("sat.outs_idle", 32'({stall_pc, stall_ifid, flush_ifid, bubble_idex, fwd_a, fwd_b}), 32'd0);

    // Randomized run against the model; small register range to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), $urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      mem_busy     = ($urandom_range(0, 7) == 0);
      run_cycle($sformatf("rnd%0d", i), 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
